icache_ctrl: RTL and testbench
==============================

# icache_ctrl

Direct-mapped instruction cache with a miss-handling FSM. Sits directly downstream of the PC unit: it takes the current PC, returns the 32-bit instruction, and holds BUSYWAIT high on a miss so the PC unit does not advance. On a miss it fetches a 128-bit block from instruction memory over a request/busywait handshake, then refills the line.

## Interface
- LINES, 8, number of cache lines; fixed at 8, so the index is 3 bits.
- BLOCK_WORDS, 4, 32-bit words per line; fixed at 4, so the block is 128 bits.
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- PC  input  32  fetch address from the PC unit.
- INSTRUCTION  output  32  instruction word for PC; combinational.
- BUSYWAIT  output  1  stall to the PC unit; combinational.
- MEM_READ  output  1  block read request to instruction memory; registered.
- MEM_ADDRESS  output  6  block address {tag, index}; registered.
- MEM_READDATA  input  128  block returned by memory; word 0 in bits [31:0].
- MEM_BUSYWAIT  input  1  high while memory is servicing a read.
- MISS_COUNT  output  16  saturating count of refills since reset.

## Operation
- Address split:
  - offset = PC[3:2]
  - index = PC[6:4]
  - tag = PC[9:7]
  - PC[1:0] are ignored.
- Valid access: PC[31:10] == 0. Any other PC, including the post-reset value 0xFFFFFFFC, is a non-access:
  - BUSYWAIT = 0, INSTRUCTION = 32'h0.
  - No state change and no miss counted.
- Per-line storage: 1 valid bit, 3-bit tag, 128-bit data.
- hit = valid[index] && tag_store[index] == tag, evaluated combinationally.
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE:
  - Valid access and hit: INSTRUCTION = word at offset, BUSYWAIT = 0.
  - Valid access and miss: BUSYWAIT = 1 in the same cycle. Next edge: go to MEM_READ, set MEM_READ = 1, MEM_ADDRESS = {tag, index}.
- MEM_READ:
  - BUSYWAIT = 1; MEM_READ and MEM_ADDRESS are held.
  - On the first edge where MEM_BUSYWAIT == 0: capture MEM_READDATA, drop MEM_READ, go to UPDATE.
- UPDATE:
  - BUSYWAIT = 1.
  - On the edge: write data, tag and valid = 1 into the line; increment MISS_COUNT (saturates at 16'hFFFF); go to IDLE.
- After UPDATE, the IDLE re-evaluation hits, so BUSYWAIT falls combinationally in that cycle.
- INSTRUCTION = 32'h0 whenever there is no hit.
- PC change while in MEM_READ or UPDATE: ignored. The refill always completes for the address latched in MEM_ADDRESS. The PC unit holds PC while BUSYWAIT = 1, so this only arises under misuse.
- Reset (RESET = 0), asynchronous and at any time, including mid-refill:
  - state = IDLE.
  - All valid bits = 0.
  - MEM_READ = 0, MEM_ADDRESS = 6'h0, MISS_COUNT = 0.
  - Tag and data arrays are not cleared.
  - An in-flight memory read is abandoned; its late MEM_BUSYWAIT fall is ignored.

## Timing
- Hit: zero-cycle latency. INSTRUCTION and BUSYWAIT settle combinationally from PC within the same cycle.
- Miss, measured from the edge on which PC presents the missing address (edge 0):
  - BUSYWAIT rises combinationally in the same cycle, before edge 1.
  - Edge 1: MEM_READ rises.
  - Memory drops MEM_BUSYWAIT after M cycles; the capture edge follows.
  - Next edge: UPDATE completes.
  - BUSYWAIT falls in the following cycle.
  - Total stall = M + 3 cycles.
- MEM_READ is asserted for exactly M+1 cycles per miss.
- Back-to-back misses to different lines: each miss pays the full penalty. No prefetch and no overlap.
- Same index, different tag: the line is replaced and the old contents are lost.
- Simultaneous reset deassertion and miss: the first edge after RESET rises begins the miss normally.

## Test plan
- Reset, then PC = 0xFFFFFFFC: INSTRUCTION = 0, BUSYWAIT = 0, MEM_READ = 0, MISS_COUNT = 0.
- Cold miss at PC = 0x000, memory block 128'h…_00000003_00000002_00000001_00000000, MEM_BUSYWAIT held for 5 cycles:
  - MEM_ADDRESS = 6'h00.
  - BUSYWAIT high for 8 cycles.
  - Then INSTRUCTION = 32'h0.
  - MISS_COUNT = 1.
- PC stepped 0x000, 0x004, 0x008, 0x00C after that refill: all hit. INSTRUCTION = 0, 1, 2, 3 in turn, BUSYWAIT stays 0, no MEM_READ.
- Conflict: PC = 0x080 (tag 1, index 0) after the 0x000 refill:
  - Miss with MEM_ADDRESS = 6'h08.
  - A return to PC = 0x000 then misses again.
  - MISS_COUNT = 3.
- Reset pulse in mid-MEM_READ (cycle 2 of 5):
  - MEM_READ drops asynchronously, state returns to IDLE.
  - PC = 0x000 misses again after reset; MISS_COUNT = 1 after that refill.
- PC = 0x400 (bit 10 set): non-access. BUSYWAIT = 0, INSTRUCTION = 0, no memory request.

Source files
------------

// File: rtl/icache_ctrl.sv
// icache_ctrl -- direct-mapped instruction cache with a refill FSM.
//
// Sits between the PC unit and instruction memory. A hit returns the
// addressed 32-bit word combinationally with BUSYWAIT low. A miss holds
// BUSYWAIT high while a 128-bit block is fetched and written into the line.
//
// Ports
//   CLK           rising-edge clock
//   RESET         asynchronous, active-low reset
//   PC            fetch address; only PC[9:0] addresses the cache
//   INSTRUCTION   instruction word for PC (0 when there is no hit)
//   BUSYWAIT      stall to the PC unit (combinational)
//   MEM_READ      registered block read request
//   MEM_ADDRESS   registered block address {tag, index}
//   MEM_READDATA  returned block, word 0 in [31:0]
//   MEM_BUSYWAIT  memory is still servicing the read
//   MISS_COUNT    saturating count of completed refills

// One cache line: the valid bit is reset; tag and data are plain storage.
module icache_line #(
  parameter int BLOCK_WORDS = 4
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         we,
  input  logic [2:0]                   wtag,
  input  logic [BLOCK_WORDS-1:0][31:0] wdata,
  output logic                         valid,
  output logic [2:0]                   tag,
  output logic [BLOCK_WORDS-1:0][31:0] data
);
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)  valid <= 1'b0;
    else if (we) valid <= 1'b1;
  end

  // Tag/data survive reset; a cleared valid bit makes them unreachable.
  always_ff @(posedge CLK) begin
    if (we) begin
      tag  <= wtag;
      data <= wdata;
    end
  end
endmodule

module icache_ctrl #(
  parameter int LINES       = 8,
  parameter int BLOCK_WORDS = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  PC,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [5:0]   MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT,
  output logic [15:0]  MISS_COUNT
);
  typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;

  state_t state;

  logic [1:0] offset;
  logic [2:0] index;
  logic [2:0] tag;
  logic       access;
  logic       hit;
  logic       unused_pc_bits;

  logic [LINES-1:0]                        line_valid;
  logic [LINES-1:0][2:0]                   line_tag;
  logic [LINES-1:0][BLOCK_WORDS-1:0][31:0] line_data;
  logic [BLOCK_WORDS-1:0][31:0]            fill_data;
  logic [BLOCK_WORDS-1:0][31:0]            sel_data;

  assign offset         = PC[3:2];
  assign index          = PC[6:4];
  assign tag            = PC[9:7];
  assign access         = (PC[31:10] == '0);
  assign unused_pc_bits = ^PC[1:0];

  // Refill targets the latched MEM_ADDRESS, never the live PC.
  for (genvar g = 0; g < LINES; g++) begin : g_line
    icache_line #(.BLOCK_WORDS(BLOCK_WORDS)) u_line (
      .CLK   (CLK),
      .RESET (RESET),
      .we    (state == S_UPDATE && MEM_ADDRESS[2:0] == 3'(g)),
      .wtag  (MEM_ADDRESS[5:3]),
      .wdata (fill_data),
      .valid (line_valid[g]),
      .tag   (line_tag[g]),
      .data  (line_data[g])
    );
  end

  assign sel_data    = line_data[index];
  assign hit         = line_valid[index] && (line_tag[index] == tag);
  assign INSTRUCTION = (access && hit) ? sel_data[offset] : 32'h0;
  // A refill in progress always stalls; in IDLE only a valid-access miss does.
  assign BUSYWAIT    = (state != S_IDLE) || (access && !hit);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= S_IDLE;
      MEM_READ    <= 1'b0;
      MEM_ADDRESS <= 6'h0;
      MISS_COUNT  <= 16'h0;
      fill_data   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access && !hit) begin
            state       <= S_MEM_READ;
            MEM_READ    <= 1'b1;
            MEM_ADDRESS <= {tag, index};
          end
        end
        S_MEM_READ: begin
          if (!MEM_BUSYWAIT) begin
            fill_data <= MEM_READDATA;
            MEM_READ  <= 1'b0;
            state     <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (MISS_COUNT != 16'hFFFF) MISS_COUNT <= MISS_COUNT + 16'd1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl. The memory model returns, for block
// address A, the words {A*4+3, A*4+2, A*4+1, A*4}, i.e. each word equals
// its own word address, and holds MEM_BUSYWAIT high for 5 edges per read.
module tb_icache_ctrl;
  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
  logic [15:0]  MISS_COUNT;

  int total = 0;
  int bad   = 0;

  localparam int M = 5;

  icache_ctrl dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT),
    .MISS_COUNT   (MISS_COUNT)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    MEM_READDATA = '0;
    for (int j = 0; j < 4; j++)
      MEM_READDATA[j*32 +: 32] = {24'h0, MEM_ADDRESS, 2'(j)};
  end

  // Memory responder: busy for M edges after MEM_READ is seen, then free.
  initial begin
    int cnt;
    cnt = 0;
    MEM_BUSYWAIT = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (MEM_READ) begin
        if (cnt < M) begin MEM_BUSYWAIT = 1'b1; cnt++; end
        else MEM_BUSYWAIT = 1'b0;
      end else begin
        cnt = 0;
        MEM_BUSYWAIT = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a missing PC and count stall cycles, MEM_READ cycles, address.
  task automatic do_miss(input logic [31:0] pc, output int stall, output int rdc,
                         output logic [5:0] addr);
    @(posedge CLK); #1 PC = pc;
    stall = 0; rdc = 0; addr = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (!BUSYWAIT) break;
      stall++;
      if (MEM_READ) begin rdc++; addr = MEM_ADDRESS; end
    end
  endtask

  task automatic step(input logic [31:0] pc);
    @(posedge CLK); #1 PC = pc;
    @(negedge CLK);
  endtask

  initial begin
    int stall, rdc;
    logic [5:0] addr;
    logic [31:0] hit_pc [4];
    hit_pc[0] = 32'h000; hit_pc[1] = 32'h004; hit_pc[2] = 32'h008; hit_pc[3] = 32'h00C;

    RESET = 1'b0;
    PC    = 32'hFFFFFFFC;
    #22;
    chk("rst_mem_read", 32'(MEM_READ), 32'h0);
    chk("rst_mem_addr", 32'(MEM_ADDRESS), 32'h0);
    chk("rst_miss_cnt", 32'(MISS_COUNT), 32'h0);
    @(negedge CLK); RESET = 1'b1;
    repeat (3) @(negedge CLK);
    chk("post_rst_instr", INSTRUCTION, 32'h0);
    chk("post_rst_busy", 32'(BUSYWAIT), 32'h0);
    chk("post_rst_mem_read", 32'(MEM_READ), 32'h0);
    chk("post_rst_miss_cnt", 32'(MISS_COUNT), 32'h0);

    // Cold miss at 0x000
    do_miss(32'h000, stall, rdc, addr);
    chk("cold_addr", 32'(addr), 32'h00);
    chk("cold_stall", 32'(stall), 32'd8);
    chk("cold_rd_cycles", 32'(rdc), 32'd6);
    chk("cold_instr", INSTRUCTION, 32'h0);
    chk("cold_miss_cnt", 32'(MISS_COUNT), 32'd1);

    // Sequential hits in the refilled line
    for (int k = 0; k < 4; k++) begin
      step(hit_pc[k]);
      chk($sformatf("hit%0d_instr", k), INSTRUCTION, 32'(k));
      chk($sformatf("hit%0d_busy", k), 32'(BUSYWAIT), 32'h0);
      chk($sformatf("hit%0d_mem_read", k), 32'(MEM_READ), 32'h0);
    end

    // Conflict: same index, tag 1
    do_miss(32'h080, stall, rdc, addr);
    chk("conf_addr", 32'(addr), 32'h08);
    chk("conf_stall", 32'(stall), 32'd8);
    chk("conf_instr", INSTRUCTION, 32'h20);
    step(32'h084);
    chk("conf_hit_instr", INSTRUCTION, 32'h21);
    do_miss(32'h000, stall, rdc, addr);
    chk("conf_back_addr", 32'(addr), 32'h00);
    chk("conf_back_stall", 32'(stall), 32'd8);
    chk("conf_back_instr", INSTRUCTION, 32'h0);
    chk("conf_miss_cnt", 32'(MISS_COUNT), 32'd3);

    // Different line: miss at index 1, word 2 -> 0x6
    do_miss(32'h018, stall, rdc, addr);
    chk("idx1_addr", 32'(addr), 32'h01);
    chk("idx1_instr", INSTRUCTION, 32'h6);
    step(32'h000);
    chk("idx0_still_hit", 32'(BUSYWAIT), 32'h0);

    // Reset in the middle of MEM_READ
    @(posedge CLK); #1 PC = 32'h080;
    repeat (3) @(posedge CLK);
    #2;
    chk("mid_mem_read_before", 32'(MEM_READ), 32'h1);
    RESET = 1'b0;
    #1;
    chk("mid_rst_mem_read", 32'(MEM_READ), 32'h0);
    chk("mid_rst_miss_cnt", 32'(MISS_COUNT), 32'h0);
    chk("mid_rst_mem_addr", 32'(MEM_ADDRESS), 32'h0);
    PC = 32'hFFFFFFFC;
    @(negedge CLK); RESET = 1'b1;
    repeat (2) @(negedge CLK);
    chk("after_rst_busy", 32'(BUSYWAIT), 32'h0);
    do_miss(32'h000, stall, rdc, addr);
    chk("rst_remiss_stall", 32'(stall), 32'd8);
    chk("rst_remiss_instr", INSTRUCTION, 32'h0);
    chk("rst_remiss_miss_cnt", 32'(MISS_COUNT), 32'd1);

    // Non-access: bit 10 set
    step(32'h400);
    chk("nonacc_busy", 32'(BUSYWAIT), 32'h0);
    chk("nonacc_instr", INSTRUCTION, 32'h0);
    repeat (3) @(negedge CLK);
    chk("nonacc_mem_read", 32'(MEM_READ), 32'h0);
    chk("nonacc_miss_cnt", 32'(MISS_COUNT), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
